// File: rtl/sm83_int_dispatch_pkg.sv
// sm83_int_pkg: shared types and defaults for the SM83 interrupt front end.
// Contents:
//   int_stage_e    - dispatch sequencer states (encoding is visible on the stage output)
//   N_IRQ_DEF      - default number of interrupt sources
//   VEC_BASE_DEF   - default restart vector of source 0
//   VEC_STRIDE_DEF - default vector spacing between sources
//   prio_idx()     - index of the lowest set bit (bit 0 = highest priority)
package sm83_int_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W1      = 3'd1,
    ST_W2      = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_PUSH_LO = 3'd4,
    ST_JUMP    = 3'd5
  } int_stage_e;

  localparam int          N_IRQ_DEF      = 5;
  localparam logic [7:0]  VEC_BASE_DEF   = 8'h40;
  localparam int          VEC_STRIDE_DEF = 8;

  // Lowest set bit wins. The result is 0 when req is empty, so callers must
  // qualify it with |req.
  function automatic logic [2:0] prio_idx(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sm83_int_dispatch_if.sv
// sm83_int_dispatch_if: bundle between the SM83 core and its interrupt front end.
// Signal protocol: there is no valid/ready pair. mcycle_en is a one-clk strobe
// marking the end of an M-cycle. instr_boundary, ei, di and reti only have
// meaning in a clk where mcycle_en is high. irq_req, if_we and if_wdata act on
// every clk. ack is a one-clk pulse that is only ever high together with
// mcycle_en.
// Modports:
//   master - core side: drives the requests, register writes and strobes.
//   slave  - interrupt front end: drives pending/ime/wake/dispatch status.
interface sm83_int_dispatch_if
  import sm83_int_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF
);
  logic             mcycle_en;
  logic             instr_boundary;
  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] ie;
  logic             if_we;
  logic [N_IRQ-1:0] if_wdata;
  logic             ei;
  logic             di;
  logic             reti;
  logic [N_IRQ-1:0] pending;
  logic             ime;
  logic             wake;
  logic             dispatch_active;
  logic [2:0]       stage;
  logic [7:0]       vector;
  logic [N_IRQ-1:0] ack;

  modport master (
    output mcycle_en, instr_boundary, irq_req, ie, if_we, if_wdata, ei, di, reti,
    input  pending, ime, wake, dispatch_active, stage, vector, ack
  );

  modport slave (
    input  mcycle_en, instr_boundary, irq_req, ie, if_we, if_wdata, ei, di, reti,
    output pending, ime, wake, dispatch_active, stage, vector, ack
  );
endinterface

// File: rtl/sm83_int_dispatch_ime.sv
// sm83_int_ime: interrupt master enable with the delayed-EI behaviour.
// Ports:
//   clk, reset      - core clock, synchronous active-high reset
//   mcycle_en       - end-of-M-cycle strobe; nothing changes without it
//   instr_boundary  - the ending M-cycle is the last one of an instruction
//   ei, di, reti    - instruction strobes, qualified by mcycle_en
//   dispatch_start  - the sequencer is entering W1 in this clk
//   ime             - master enable
module sm83_int_ime (
  input  logic clk,
  input  logic reset,
  input  logic mcycle_en,
  input  logic instr_boundary,
  input  logic ei,
  input  logic di,
  input  logic reti,
  input  logic dispatch_start,
  output logic ime
);
  // EI delay: loaded with 2 by EI and decremented at each later instruction
  // boundary. IME turns on when it reaches zero, which is at the end of the
  // instruction that follows EI.
  logic [1:0] ei_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ime    <= 1'b0;
      ei_cnt <= 2'd0;
    end else if (mcycle_en) begin
      if (dispatch_start || di) begin
        // Dispatch entry and DI both win over any armed EI.
        ime    <= 1'b0;
        ei_cnt <= 2'd0;
      end else if (reti) begin
        ime    <= 1'b1;
        ei_cnt <= 2'd0;
      end else if (ei) begin
        // EI while already enabled has no effect.
        if (!ime) ei_cnt <= 2'd2;
      end else if (instr_boundary && (ei_cnt != 2'd0)) begin
        ei_cnt <= ei_cnt - 2'd1;
        if (ei_cnt == 2'd1) ime <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/sm83_int_dispatch.sv
// sm83_int_dispatch: SM83 interrupt front end. It holds the IF pending bits and
// the master enable, and runs the 5-M-cycle dispatch sequencer.
// Ports:
//   clk, reset - core clock, synchronous active-high reset
//   bus        - sm83_int_dispatch_if.slave:
//     inputs  mcycle_en, instr_boundary, irq_req, ie, if_we, if_wdata, ei, di, reti
//     outputs pending (IF), ime, wake (any enabled pending, ignores ime),
//             dispatch_active, stage (sequencer state), vector (restart
//             address, valid in JUMP), ack (one-hot IF clear pulse)
// N_IRQ must be 8 or less; prio_idx works on 8 bits.
module sm83_int_dispatch
  import sm83_int_pkg::*;
#(
  parameter int         N_IRQ      = N_IRQ_DEF,
  parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic              clk,
  input logic              reset,
  sm83_int_dispatch_if.slave bus
);
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_W1      = ST_W1;
  localparam logic [2:0] S_W2      = ST_W2;
  localparam logic [2:0] S_PUSH_HI = ST_PUSH_HI;
  localparam logic [2:0] S_PUSH_LO = ST_PUSH_LO;
  localparam logic [2:0] S_JUMP    = ST_JUMP;

  logic [2:0]       stage_q;
  logic [2:0]       stage_d;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] ack_d;
  logic [7:0]       vector_q;
  logic [7:0]       vector_calc;
  logic [2:0]       idx;
  logic             any_req;
  logic             pick;
  logic             dispatch_start;
  logic             ime_q;

  assign masked  = pending_q & bus.ie;
  assign any_req = |masked;
  assign idx     = prio_idx(8'(masked));

  // The serviced source is chosen at the PUSH_HI -> PUSH_LO edge. Gating with
  // reset keeps a reset in that clk from clearing an IF bit.
  assign pick = bus.mcycle_en && (stage_q == S_PUSH_HI) && !reset;

  assign dispatch_start = bus.mcycle_en && bus.instr_boundary && ime_q &&
                          any_req && (stage_q == S_IDLE) && !reset;

  assign vector_calc = VEC_BASE + 8'(int'(idx) * VEC_STRIDE);

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_d[i] = pick && any_req && (idx == 3'(i));
    end
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.mcycle_en) begin
      case (stage_q)
        S_IDLE:    if (dispatch_start) stage_d = S_W1;
        S_W1:      stage_d = S_W2;
        S_W2:      stage_d = S_PUSH_HI;
        S_PUSH_HI: stage_d = S_PUSH_LO;
        S_PUSH_LO: stage_d = S_JUMP;
        S_JUMP:    stage_d = S_IDLE;
        default:   stage_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= S_IDLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  // A request in the same clk as an ack or a write of its bit wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= ((bus.if_we ? bus.if_wdata : pending_q) & ~ack_d) | bus.irq_req;
    end
  end

  // When the dispatch is cancelled (nothing enabled and pending at the pick
  // edge) the vector is 8'h00. The dispatch still runs to the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      vector_q <= 8'h00;
    end else if (pick) begin
      vector_q <= any_req ? vector_calc : 8'h00;
    end
  end

  sm83_int_ime u_ime (
    .clk            (clk),
    .reset          (reset),
    .mcycle_en      (bus.mcycle_en),
    .instr_boundary (bus.instr_boundary),
    .ei             (bus.ei),
    .di             (bus.di),
    .reti           (bus.reti),
    .dispatch_start (dispatch_start),
    .ime            (ime_q)
  );

  assign bus.pending         = pending_q;
  assign bus.ime             = ime_q;
  assign bus.wake            = any_req;
  assign bus.dispatch_active = (stage_q != S_IDLE);
  assign bus.stage           = stage_q;
  assign bus.vector          = vector_q;
  assign bus.ack             = ack_d;
endmodule

// File: tb/tb_sm83_int_dispatch.sv
// Testbench for sm83_int_dispatch. Directed scenarios drive the core-side
// strobes. Each dispatch pushes its expected {ack, vector, pending, ime} result
// into exp_q, and a negedge monitor pops and compares it when the DUT enters JUMP.
module tb_sm83_int_dispatch;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sm83_int_dispatch_if #(.N_IRQ(5)) bus ();

  sm83_int_dispatch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // {ack[4:0], vector[7:0], pending[4:0], ime}
  logic [18:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [4:0]  ack_cap;
  logic [2:0]  prev_stage;
  logic [18:0] exp_v;
  logic [18:0] act_v;

  always @(negedge clk) begin
    if (reset) begin
      ack_cap    = 5'd0;
      prev_stage = 3'd0;
    end else begin
      if (!bus.mcycle_en) begin
        total++;
        if (bus.ack !== 5'd0) begin
          bad++;
          $display("FAIL ack_idle: got %0h expected 0", bus.ack);
        end
      end
      if (bus.mcycle_en && (bus.stage == 3'd3)) ack_cap = bus.ack;
      if ((bus.stage == 3'd5) && (prev_stage != 3'd5)) begin
        act_v = {ack_cap, bus.vector, bus.pending, bus.ime};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL jump_unexpected: got %0h expected none", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL jump_result: got %0h expected %0h", act_v, exp_v);
          end
        end
        ack_cap = 5'd0;
      end
      prev_stage = bus.stage;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcyc(input logic ib, input logic e = 1'b0, input logic d = 1'b0,
                      input logic r = 1'b0, input logic [4:0] irq = 5'd0);
    bus.mcycle_en      = 1'b1;
    bus.instr_boundary = ib;
    bus.ei             = e;
    bus.di             = d;
    bus.reti           = r;
    bus.irq_req        = irq;
    tick();
    bus.mcycle_en      = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.ei             = 1'b0;
    bus.di             = 1'b0;
    bus.reti           = 1'b0;
    bus.irq_req        = 5'd0;
    tick();
  endtask

  task automatic write_if(input logic [4:0] v);
    bus.if_we    = 1'b1;
    bus.if_wdata = v;
    tick();
    bus.if_we    = 1'b0;
    bus.if_wdata = 5'd0;
  endtask

  task automatic pulse_irq(input logic [4:0] v);
    bus.irq_req = v;
    tick();
    bus.irq_req = 5'd0;
  endtask

  // Starts at an instruction boundary and walks all five stages back to IDLE.
  task automatic run_dispatch(input string tag);
    mcyc(1'b1);
    check({tag, "_w1"}, bus.stage, 3'd1);
    for (int s = 2; s <= 5; s++) begin
      mcyc(1'b0);
      check({tag, "_stage"}, bus.stage, 32'(s));
    end
    mcyc(1'b0);
    check({tag, "_idle"}, bus.stage, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.mcycle_en      = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.irq_req        = 5'd0;
    bus.ie             = 5'd0;
    bus.if_we          = 1'b0;
    bus.if_wdata       = 5'd0;
    bus.ei             = 1'b0;
    bus.di             = 1'b0;
    bus.reti           = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_pending", bus.pending, 5'd0);
    check("rst_ime", bus.ime, 1'b0);
    check("rst_stage", bus.stage, 3'd0);
    check("rst_vector", bus.vector, 8'h00);
    check("rst_ack", bus.ack, 5'd0);
    check("rst_wake", bus.wake, 1'b0);
    check("rst_active", bus.dispatch_active, 1'b0);

    // Source 2 via RETI-enabled IME.
    bus.ie = 5'b00100;
    pulse_irq(5'b00100);
    check("t1_pending", bus.pending, 5'b00100);
    check("t1_wake", bus.wake, 1'b1);
    mcyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_ime_reti", bus.ime, 1'b1);
    exp_q.push_back({5'b00100, 8'h50, 5'b00000, 1'b0});
    run_dispatch("t1");
    check("t1_ime_after", bus.ime, 1'b0);
    check("t1_pending_after", bus.pending, 5'b00000);

    // Two pending, lowest index wins.
    bus.ie = 5'b11111;
    pulse_irq(5'b10010);
    mcyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({5'b00010, 8'h48, 5'b10000, 1'b0});
    run_dispatch("t2");
    check("t2_pending_after", bus.pending, 5'b10000);
    check("t2_active", bus.dispatch_active, 1'b0);
    write_if(5'b00000);
    check("t2_clear", bus.pending, 5'b00000);

    // EI delay: enable lands after the following instruction.
    write_if(5'b00001);
    mcyc(1'b1, 1'b1);
    check("t3_ime_ei", bus.ime, 1'b0);
    mcyc(1'b1);
    check("t3_ime_b1", bus.ime, 1'b0);
    check("t3_stage_b1", bus.stage, 3'd0);
    mcyc(1'b1);
    check("t3_ime_b2", bus.ime, 1'b1);
    check("t3_stage_b2", bus.stage, 3'd0);
    exp_q.push_back({5'b00001, 8'h40, 5'b00000, 1'b0});
    run_dispatch("t3");

    // EI followed by DI leaves IME off.
    mcyc(1'b1, 1'b1);
    mcyc(1'b1, 1'b0, 1'b1);
    mcyc(1'b1);
    mcyc(1'b1);
    check("t3b_ime_di", bus.ime, 1'b0);

    // Cancellation: IF cleared during PUSH_HI.
    write_if(5'b01000);
    mcyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({5'b00000, 8'h00, 5'b00000, 1'b0});
    mcyc(1'b1);
    mcyc(1'b0);
    mcyc(1'b0);
    check("t4_push_hi", bus.stage, 3'd3);
    write_if(5'b00000);
    mcyc(1'b0);
    check("t4_push_lo", bus.stage, 3'd4);
    mcyc(1'b0);
    check("t4_jump", bus.stage, 3'd5);
    check("t4_vector", bus.vector, 8'h00);
    mcyc(1'b0);
    check("t4_idle", bus.stage, 3'd0);

    // Request for bit 3 in the same clk as its ack.
    bus.ie = 5'b01000;
    write_if(5'b01000);
    mcyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({5'b01000, 8'h58, 5'b01000, 1'b0});
    mcyc(1'b1);
    mcyc(1'b0);
    mcyc(1'b0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b01000);
    check("t5_pending_kept", bus.pending, 5'b01000);
    mcyc(1'b0);
    mcyc(1'b0);
    check("t5_idle", bus.stage, 3'd0);
    mcyc(1'b1);
    check("t5_no_redispatch", bus.stage, 3'd0);
    write_if(5'b00000);

    // Wake without IME, then reset during W2.
    bus.ie = 5'b00001;
    pulse_irq(5'b00001);
    check("t6_wake", bus.wake, 1'b1);
    mcyc(1'b1);
    check("t6_no_dispatch", bus.stage, 3'd0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b1);
    mcyc(1'b1);
    mcyc(1'b0);
    check("t6_w2", bus.stage, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_stage", bus.stage, 3'd0);
    check("t6_rst_wake", bus.wake, 1'b0);
    check("t6_rst_ime", bus.ime, 1'b0);
    check("t6_rst_vector", bus.vector, 8'h00);
    check("t6_rst_active", bus.dispatch_active, 1'b0);

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sm83_int_dispatch.md
Name: sm83_int_dispatch

Overview:
- Interrupt front end of the SM83 core. Holds the five interrupt-flag (IF) pending bits, the master enable (IME) with its delayed-EI behaviour, and the 5-M-cycle dispatch sequencer.
- Produces the set/clear strobes and the level outputs consumed by the core's control latches (halt/wake, dispatch-in-progress), and the restart vector placed on the address path.

Parameters:
- N_IRQ, 5, number of interrupt sources; bit 0 is highest priority.
- VEC_BASE, 8'h40, vector of source 0.
- VEC_STRIDE, 8, vector spacing between sources.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mcycle_en  input  1  one-clk strobe marking the end of an M-cycle; the FSM and IME advance only when it is high.
- instr_boundary  input  1  qualifies mcycle_en: the current M-cycle is the last one of an instruction (opcode fetch follows).
- irq_req  input  N_IRQ  request pulses or levels from peripherals; set IF bits.
- ie  input  N_IRQ  interrupt-enable register contents.
- if_we  input  1  CPU write to IF.
- if_wdata  input  N_IRQ  IF write data.
- ei  input  1  EI executed (strobe, qualified by mcycle_en).
- di  input  1  DI executed (strobe, qualified by mcycle_en).
- reti  input  1  RETI executed (strobe, qualified by mcycle_en).
- pending  output  N_IRQ  IF register.
- ime  output  1  interrupt master enable.
- wake  output  1  combinational OR of (pending & ie), independent of ime; releases HALT.
- dispatch_active  output  1  high while the FSM is not IDLE.
- stage  output  3  FSM state encoding.
- vector  output  8  restart address; valid in JUMP.
- ack  output  N_IRQ  one-hot, one-clk pulse clearing the serviced IF bit.

Behaviour:
- Reset (synchronous): pending=0, ime=0, EI delay counter=0, stage=IDLE, vector=8'h00, ack=0.
  - dispatch_active=0.
  - wake=0 because pending=0.
- IF register, per clk:
  - next = (if_we ? if_wdata : pending) & ~ack | irq_req.
  - A request on the same clk as an ack or write of the same bit wins, so the bit stays 1.
- IME:
  - di: clears ime immediately and cancels any pending EI delay.
  - reti: sets ime at that mcycle_en.
  - ei: arms a 2-step delay. ime becomes 1 at the second instr_boundary mcycle_en after the EI strobe, i.e. after the following instruction completes.
  - ei while ime=1 has no effect.
  - ei immediately followed by di leaves ime=0.
  - Entering W1 clears ime and the EI delay.
- FSM (advances only on mcycle_en):
  - IDLE → W1 when instr_boundary & ime & |(pending & ie).
  - W1 → W2 → PUSH_HI → PUSH_LO → JUMP → IDLE, one M-cycle each, 5 M-cycles total.
- Priority and vector:
  - The serviced source is chosen at the PUSH_HI → PUSH_LO transition: the lowest index set in (pending & ie) at that clk.
  - ack pulses for that bit in the same clk.
  - vector = VEC_BASE + idx*VEC_STRIDE, registered; held through JUMP.
- Cancellation: if (pending & ie)==0 at that transition (the bit was cleared by an IF/IE write during PUSH_HI), there is no ack and vector=8'h00. Dispatch still completes.
- A new request arriving mid-dispatch stays pending. It is serviced only after ime is re-enabled.
- reset mid-dispatch returns to IDLE on that clk with no ack.
- ack is 0 whenever mcycle_en is 0.
- stage encoding: IDLE=0, W1=1, W2=2, PUSH_HI=3, PUSH_LO=4, JUMP=5.

Decomposition:
- Package sm83_int_pkg holds:
  - typedef int_stage_e (the six states);
  - localparams N_IRQ_DEF, VEC_BASE_DEF, VEC_STRIDE_DEF;
  - a function prio_idx returning the lowest set bit.
- One natural sub-module: sm83_int_ime, the IME plus EI-delay logic with inputs ei, di, reti, dispatch_start.

Test Plan:
- reset; irq_req=5'b00100 pulse, ie=5'b00100, ime=1 via reti → at next instr_boundary stage sequences 1..5, then ack=5'b00100 at PUSH_HI→PUSH_LO, vector=8'h50, ime=0, pending=0.
- pending=5'b10010, ie=5'b11111, ime=1 → source 1 serviced, vector=8'h48, pending=5'b10000 afterwards.
- ei strobe, then two instr_boundary strobes with pending&ie≠0 → ime=0 after the first strobe, 1 after the second; dispatch starts on the third boundary.
- dispatch running; if_we with if_wdata=0 during PUSH_HI → no ack, vector=8'h00, FSM returns to IDLE after JUMP.
- irq_req bit 3 asserted in the same clk as ack for bit 3 → pending[3] stays 1.
- ime=0, ie=5'b00001, irq_req bit 0 → wake=1, no dispatch; reset asserted during W2 → next clk stage=0, wake=0.
